// File: rtl/despachador_llamadas.sv
// rtl/despachador_llamadas.sv - floor-call dispatcher driving sube/baja into maquina_estados
//
// Latches the floor-call buttons, serves them in SCAN order and issues
// one-cycle move commands to maquina_estados. It also opens the door at
// requested floors and raises a sticky fault when the car does not follow
// a command.
//
// Parameters:
//   PISO_W    floor-index width, N = 2**PISO_W floors
//   T_PUERTA  door-open dwell in clock cycles (>= 1)
//   T_TIMEOUT max cycles to wait for piso to change after a move (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   en          enable: gates new call latching and new moves
//   llamada     call buttons, bit i requests floor i
//   piso        current floor reported by maquina_estados
//   sube/baja   one-cycle move-up / move-down commands
//   puerta      door open
//   falla       sticky fault flag, cleared only by rst
//   pendientes  latched pending calls
//
// Optional build macro:
//   DESPACHO_REAPERTURA_EN  a press at the current floor while the door is
//                           open restarts the dwell counter.

module despachador_llamadas #(
    parameter int PISO_W    = 2,
    parameter int T_PUERTA  = 8,
    parameter int T_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [(1<<PISO_W)-1:0] llamada,
    input  logic [PISO_W-1:0]     piso,
    output logic                  sube,
    output logic                  baja,
    output logic                  puerta,
    output logic                  falla,
    output logic [(1<<PISO_W)-1:0] pendientes
);

    localparam int N     = 1 << PISO_W;
    localparam int T_MAX = (T_PUERTA > T_TIMEOUT) ? T_PUERTA : T_TIMEOUT;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0]     LIM_PUERTA  = CW'(T_PUERTA - 1);
    localparam logic [CW-1:0]     LIM_TIMEOUT = CW'(T_TIMEOUT - 1);
    localparam logic [PISO_W-1:0] UNO         = PISO_W'(1);

    typedef enum logic [2:0] {
        REPOSO,
        PULSO_SUBE,
        PULSO_BAJA,
        ESPERA,
        PUERTA,
        FALLA
    } estado_t;

    estado_t           estado_q, estado_d;
    logic              dir_q, dir_d;            // 1 = up, 0 = down
    logic [PISO_W-1:0] piso_ini_q, piso_ini_d;
    logic [CW-1:0]     cnt_q, cnt_d;            // timeout count in ESPERA, dwell count in PUERTA
    logic [N-1:0]      pend_q, pend_d;
    logic              sube_q, baja_q, puerta_q, falla_q;

    logic              hay_arriba, hay_abajo;
    logic [PISO_W-1:0] destino;

    // Pending calls strictly above / below the current floor.
    always_comb begin
        hay_arriba = 1'b0;
        hay_abajo  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pend_q[i]) begin
                if (i > int'(piso)) hay_arriba = 1'b1;
                if (i < int'(piso)) hay_abajo  = 1'b1;
            end
        end
    end

    // dir_q already holds the direction of the move in flight.
    assign destino = dir_q ? (piso_ini_q + UNO) : (piso_ini_q - UNO);

    always_comb begin
        estado_d   = estado_q;
        dir_d      = dir_q;
        piso_ini_d = piso_ini_q;
        cnt_d      = cnt_q;

        case (estado_q)
            REPOSO: begin
                if (en && (pend_q != '0)) begin
                    if (pend_q[piso]) begin
                        estado_d = PUERTA;
                        cnt_d    = '0;
                    end else if (dir_q) begin
                        if (hay_arriba) begin
                            estado_d = PULSO_SUBE;
                        end else if (hay_abajo) begin
                            dir_d    = 1'b0;
                            estado_d = PULSO_BAJA;
                        end
                    end else begin
                        if (hay_abajo) begin
                            estado_d = PULSO_BAJA;
                        end else if (hay_arriba) begin
                            dir_d    = 1'b1;
                            estado_d = PULSO_SUBE;
                        end
                    end
                    // Starting floor is taken on entry to the pulse so that a car
                    // reacting within the pulse cycle is still measured correctly.
                    piso_ini_d = piso;
                end
            end

            PULSO_SUBE, PULSO_BAJA: begin
                estado_d = ESPERA;
                cnt_d    = '0;
            end

            ESPERA: begin
                cnt_d = cnt_q + CW'(1);
                if (piso == destino) begin
                    if (pend_q[piso]) begin
                        estado_d = PUERTA;
                        cnt_d    = '0;
                    end else begin
                        estado_d = REPOSO;
                    end
                end else if (piso != piso_ini_q) begin
                    estado_d = FALLA;
                end else if (cnt_q == LIM_TIMEOUT) begin
                    estado_d = FALLA;
                end
            end

            PUERTA: begin
`ifdef DESPACHO_REAPERTURA_EN
                if (llamada[piso]) begin
                    cnt_d = '0;
                end else if (cnt_q == LIM_PUERTA) begin
                    estado_d = REPOSO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`else
                if (cnt_q == LIM_PUERTA) begin
                    estado_d = REPOSO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end

            FALLA: begin
                estado_d = FALLA;
            end

            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    // Pending-call register: the current floor's bit is forced clear on entry
    // to PUERTA and for the whole door phase, so clearing beats a new press.
    always_comb begin
        pend_d = pend_q;
        if (en && (estado_q != FALLA)) begin
            pend_d = pend_q | llamada;
        end
        if ((estado_d == PUERTA) || (estado_q == PUERTA)) begin
            pend_d[piso] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= REPOSO;
            dir_q      <= 1'b1;
            piso_ini_q <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            sube_q     <= 1'b0;
            baja_q     <= 1'b0;
            puerta_q   <= 1'b0;
            falla_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            dir_q      <= dir_d;
            piso_ini_q <= piso_ini_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            sube_q     <= (estado_d == PULSO_SUBE);
            baja_q     <= (estado_d == PULSO_BAJA);
            puerta_q   <= (estado_d == PUERTA);
            falla_q    <= (estado_d == FALLA);
        end
    end

    assign sube       = sube_q;
    assign baja       = baja_q;
    assign puerta     = puerta_q;
    assign falla      = falla_q;
    assign pendientes = pend_q;

endmodule

// File: tb/tb_despachador_llamadas.sv
// tb/tb_despachador_llamadas.sv - directed self-checking bench for despachador_llamadas

module tb_despachador_llamadas;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] llamada;
    logic [1:0] piso;
    logic       sube;
    logic       baja;
    logic       puerta;
    logic       falla;
    logic [3:0] pendientes;

    int checks = 0;
    int errors = 0;

    despachador_llamadas #(
        .PISO_W   (2),
        .T_PUERTA (8),
        .T_TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .llamada   (llamada),
        .piso      (piso),
        .sube      (sube),
        .baja      (baja),
        .puerta    (puerta),
        .falla     (falla),
        .pendientes(pendientes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulsar(input logic [3:0] v);
        llamada = v;
        @(negedge clk);
        llamada = 4'b0000;
    endtask

    // Waits (bounded) for a move command; returns {sube,baja} as seen.
    task automatic esperar_pulso(output logic [1:0] sb);
        sb = 2'b00;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sube || baja) begin
                sb = {sube, baja};
                break;
            end
        end
    endtask

    // Car model: expects one move command, checks its width, then moves piso.
    task automatic mover(input logic arriba, input string tag);
        logic [1:0] sb;
        esperar_pulso(sb);
        chk(tag, 32'(sb), arriba ? 32'h2 : 32'h1);
        @(negedge clk);
        chk({tag, "_ancho"}, 32'({sube, baja}), 32'h0);
        if (sb != 2'b00) piso = arriba ? piso + 2'd1 : piso - 2'd1;
    endtask

    // Waits for the door, counts its open cycles; presses the current floor
    // during the open cycle numbered 'presion' (0 = no press).
    task automatic medir_puerta(input int presion, output int largo);
        logic hallada;
        hallada = 1'b0;
        largo   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (puerta) begin
                hallada = 1'b1;
                break;
            end
        end
        while (hallada && puerta && largo < 60) begin
            largo++;
            if (largo == presion) llamada = 4'b0001 << piso;
            @(negedge clk);
            llamada = 4'b0000;
        end
    endtask

    initial begin
        int         largo;
        logic [1:0] sb;
        logic       visto;

        rst     = 1'b1;
        en      = 1'b0;
        llamada = 4'b0000;
        piso    = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_salidas", 32'({sube, baja, puerta, falla}), 32'h0);
        chk("reset_pend", 32'(pendientes), 32'h0);
        rst = 1'b0;
        en  = 1'b1;

        // Single call two floors up: latency, two sube pulses, door, cleared.
        @(negedge clk);
        pulsar(4'b0100);
        chk("t1_pend", 32'(pendientes), 32'h4);
        chk("t1_sin_sube_aun", 32'(sube), 32'h0);
        @(negedge clk);
        chk("t1_sube_latencia", 32'({sube, baja}), 32'h2);
        @(negedge clk);
        chk("t1_sube_ancho", 32'({sube, baja}), 32'h0);
        piso = 2'd1;
        mover(1'b1, "t1_sube2");
        medir_puerta(0, largo);
        chk("t1_puerta_largo", 32'(largo), 32'd8);
        chk("t1_pend_final", 32'(pendientes), 32'h0);
        visto = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (sube || baja || puerta) visto = 1'b1;
        end
        chk("t1_quieto", 32'(visto), 32'h0);

        // Calls above and below at once from floor 1, heading up: SCAN order.
        reset_dut();
        piso = 2'd1;
        pulsar(4'b1001);
        mover(1'b1, "t2_sube_a2");
        mover(1'b1, "t2_sube_a3");
        medir_puerta(0, largo);
        chk("t2_puerta3", 32'(largo), 32'd8);
        chk("t2_pend_tras3", 32'(pendientes), 32'h1);
        mover(1'b0, "t2_baja_a2");
        mover(1'b0, "t2_baja_a1");
        mover(1'b0, "t2_baja_a0");
        medir_puerta(0, largo);
        chk("t2_puerta0", 32'(largo), 32'd8);
        chk("t2_pend_final", 32'(pendientes), 32'h0);

        // Car never moves: timeout fault 16 cycles after the pulse ends.
        reset_dut();
        piso = 2'd2;
        pulsar(4'b1000);
        esperar_pulso(sb);
        chk("t3_sube", 32'(sb), 32'h2);
        repeat (16) @(negedge clk);
        chk("t3_falla_aun_no", 32'(falla), 32'h0);
        @(negedge clk);
        chk("t3_falla", 32'(falla), 32'h1);
        chk("t3_salidas_falla", 32'({sube, baja, puerta}), 32'h0);
        pulsar(4'b0001);
        @(negedge clk);
        chk("t3_pend_congelado", 32'(pendientes), 32'h8);
        chk("t3_falla_pegajosa", 32'(falla), 32'h1);
        reset_dut();
        chk("t3_rst_falla", 32'(falla), 32'h0);
        chk("t3_rst_pend", 32'(pendientes), 32'h0);

        // Car jumps to the wrong floor: fault on the next edge.
        piso = 2'd1;
        pulsar(4'b0100);
        esperar_pulso(sb);
        chk("t4_sube", 32'(sb), 32'h2);
        @(negedge clk);
        piso = 2'd3;
        @(negedge clk);
        chk("t4_falla", 32'(falla), 32'h1);

        // Calls while disabled are lost; async reset during the door phase.
        reset_dut();
        piso = 2'd1;
        en   = 1'b0;
        llamada = 4'b0010;
        repeat (2) @(negedge clk);
        llamada = 4'b0000;
        chk("t5_en0_pend", 32'(pendientes), 32'h0);
        visto = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (sube || baja || puerta) visto = 1'b1;
        end
        chk("t5_en0_quieto", 32'(visto), 32'h0);
        en   = 1'b1;
        piso = 2'd0;
        pulsar(4'b1001);
        visto = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (puerta) begin
                visto = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_puerta_abierta", 32'(visto), 32'h1);
        chk("t5_pend_en_puerta", 32'(pendientes), 32'h8);
        rst = 1'b1;
        #1;
        chk("t5_rst_puerta", 32'(puerta), 32'h0);
        chk("t5_rst_pend", 32'(pendientes), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Press at the open floor during dwell cycle 5.
        piso = 2'd1;
        pulsar(4'b0010);
        medir_puerta(5, largo);
`ifdef DESPACHO_REAPERTURA_EN
        chk("t6_puerta_reapertura", 32'(largo), 32'd13);
`else
        chk("t6_puerta_fija", 32'(largo), 32'd8);
`endif
        chk("t6_pend", 32'(pendientes), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
